// File: rtl/memory_arbiter.sv
// Two-port round-robin arbiter sharing one memory port; one transaction in flight,
// combinational issue and response paths, offer rotated on every idle ready cycle.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  output logic                    req0_ready,
  input  logic                    req0_enable,
  input  logic                    req0_command,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_wdata,
  input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
  output logic                    req0_valid,

  output logic                    req1_ready,
  input  logic                    req1_enable,
  input  logic                    req1_command,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_wdata,
  input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
  output logic                    req1_valid,

  output logic [DATA_WIDTH-1:0]   req_rdata,

  input  logic                    mem_ready,
  output logic                    mem_enable,
  output logic                    mem_command,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,

  output logic                    owner,
  output logic                    busy,
  output logic                    protocol_error
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;
  logic   offer_q, offer_d;
  logic   owner_q, owner_d;
  logic   perr_q,  perr_d;
  logic   sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      offer_q <= 1'b0;
      owner_q <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      offer_q <= offer_d;
      owner_q <= owner_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    offer_d    = offer_q;
    owner_d    = owner_q;
    perr_d     = perr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    mem_enable = 1'b0;
    case (state_q)
      IDLE: begin
        // Ready never looks at enable, so the requester's enable-from-ready path stays acyclic.
        req0_ready = mem_ready && !offer_q;
        req1_ready = mem_ready &&  offer_q;
        mem_enable = offer_q ? (req1_enable && req1_ready) : (req0_enable && req0_ready);
        if (mem_enable) begin
          state_d = BUSY;
          owner_d = offer_q;
          offer_d = ~offer_q;
        end else if (mem_ready) begin
          offer_d = ~offer_q;
        end
        if (mem_valid) perr_d = 1'b1;
      end
      BUSY: begin
        // A response coinciding with reset belongs to an abandoned transaction.
        req0_valid = mem_valid && !reset && !owner_q;
        req1_valid = mem_valid && !reset &&  owner_q;
        if (mem_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel         = (state_q == BUSY) ? owner_q : offer_q;
  assign mem_command = sel ? req1_command : req0_command;
  assign mem_addr    = sel ? req1_addr    : req0_addr;
  assign mem_wdata   = sel ? req1_wdata   : req0_wdata;
  assign mem_wstrb   = sel ? req1_wstrb   : req0_wstrb;

  assign req_rdata      = mem_rdata;
  assign owner          = owner_q;
  assign busy           = (state_q == BUSY);
  assign protocol_error = perr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: latency-programmable memory model plus per-port
// queues of expected read data, checked as responses come back.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_ready, req0_enable, req0_command, req0_valid;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_wstrb;
  logic        req1_ready, req1_enable, req1_command, req1_valid;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_wstrb;
  logic [31:0] req_rdata;
  logic        mem_ready, mem_enable, mem_command, mem_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        owner, busy, protocol_error;

  int errors = 0;
  int checks = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // memory model
  int          lat = 2;
  logic        auto_mem = 1'b1;
  logic        inj_valid = 1'b0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_rdata = '0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .req0_ready(req0_ready), .req0_enable(req0_enable), .req0_command(req0_command),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb), .req0_valid(req0_valid),
    .req1_ready(req1_ready), .req1_enable(req1_enable), .req1_command(req1_command),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb), .req1_valid(req1_valid),
    .req_rdata(req_rdata),
    .mem_ready(mem_ready), .mem_enable(mem_enable), .mem_command(mem_command),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .protocol_error(protocol_error)
  );

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ((a * 32'h9E3779B1) ^ 32'h5A5A5A5A);
  endfunction

  always @(posedge clk) begin
    if (reset) m_pend <= 1'b0;
    else if (m_pend) begin
      if (m_cnt == 0) m_pend <= 1'b0;
      else m_cnt <= m_cnt - 1;
    end else if (auto_mem && mem_enable && mem_ready) begin
      m_pend  <= 1'b1;
      m_cnt   <= lat - 1;
      m_rdata <= mem_fn(mem_addr);
    end
  end

  assign mem_valid = (m_pend && m_cnt == 0) || inj_valid;
  assign mem_rdata = m_pend ? m_rdata : 32'h0;

  task automatic do_reset();
    reset = 1'b1;
    req0_enable = 1'b0; req1_enable = 1'b0;
    inj_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req0_addr = 32'hAAA0; req1_addr = 32'h5550;
    mem_ready = 1'b0;
    do_reset();
    #1;
    checks++;
    if (busy !== 1'b0 || owner !== 1'b0 || protocol_error !== 1'b0) begin
      errors++; $display("FAIL reset_regs: busy=%b owner=%b perr=%b, need 0 0 0", busy, owner, protocol_error);
    end
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_enable !== 1'b0 || req0_valid !== 1'b0 || req1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: r0=%b r1=%b en=%b v0=%b v1=%b, need all 0",
                         req0_ready, req1_ready, mem_enable, req0_valid, req1_valid);
    end
    checks++;
    if (mem_addr !== 32'hAAA0) begin
      errors++; $display("FAIL reset_addr_mux: got %h need %h", mem_addr, 32'hAAA0);
    end
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #1;
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1) || busy !== 1'b0) begin
        errors++; $display("FAIL idle_rotation[%0d]: r0=%b r1=%b busy=%b, need %b %b 0",
                           i, req0_ready, req1_ready, busy, (i % 2 == 0), (i % 2 == 1));
      end
    end
  endtask

  task automatic test_read();
    logic [31:0] e;
    do_reset();
    lat = 3;
    req0_command = 1'b0; req0_addr = 32'h100; req0_enable = 1'b1;
    #1;
    checks++;
    if (mem_enable !== 1'b1 || mem_addr !== 32'h100 || mem_command !== 1'b0 || owner !== 1'b0) begin
      errors++; $display("FAIL read_issue: en=%b addr=%h cmd=%b owner=%b, need 1 100 0 0",
                         mem_enable, mem_addr, mem_command, owner);
    end else q0.push_back(mem_fn(32'h100));
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      req0_enable = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || mem_addr !== 32'h100 || owner !== 1'b0 || mem_enable !== 1'b0 ||
          req1_valid !== 1'b0 || req0_valid !== (i == 3)) begin
        errors++; $display("FAIL read_busy[%0d]: busy=%b addr=%h owner=%b en=%b v0=%b v1=%b",
                           i, busy, mem_addr, owner, mem_enable, req0_valid, req1_valid);
      end
      if (req0_valid === 1'b1) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL read_unexpected: valid with no outstanding read");
        end else begin
          e = q0.pop_front();
          if (req_rdata !== e) begin
            errors++; $display("FAIL read_data: got %h need %h", req_rdata, e);
          end
        end
      end
    end
    @(posedge clk); #2;
    checks++;
    if (busy !== 1'b0 || q0.size() != 0) begin
      errors++; $display("FAIL read_done: busy=%b pending=%0d, need 0 0", busy, q0.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a0, a1, e;
    int c0, c1, p;
    do_reset();
    lat = 2;
    a0 = 32'h1000; a1 = 32'h2000; c0 = 0; c1 = 0;
    req0_command = 1'b0; req1_command = 1'b0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      req0_addr = a0; req1_addr = a1;
      req0_enable = req0_ready; req1_enable = req1_ready;
      #1;
      if (mem_enable === 1'b1) begin
        p = req1_enable ? 1 : 0;
        checks++;
        if (cyc % 3 != 0 || p != (cyc / 3) % 2 || mem_addr !== (p == 1 ? a1 : a0)) begin
          errors++; $display("FAIL issue_order: cycle %0d port %0d addr %h, need port %0d on a multiple of 3",
                             cyc, p, mem_addr, (cyc / 3) % 2);
        end
        if (p == 1) q1.push_back(mem_fn(a1)); else q0.push_back(mem_fn(a0));
      end
      if (req0_valid === 1'b1) begin
        checks++;
        e = (q0.size() != 0) ? q0.pop_front() : ~req_rdata;
        if (req_rdata !== e) begin
          errors++; $display("FAIL rr_data0: got %h need %h", req_rdata, e);
        end
        a0 += 4; c0++;
      end
      if (req1_valid === 1'b1) begin
        checks++;
        e = (q1.size() != 0) ? q1.pop_front() : ~req_rdata;
        if (req_rdata !== e) begin
          errors++; $display("FAIL rr_data1: got %h need %h", req_rdata, e);
        end
        a1 += 4; c1++;
      end
    end
    checks++;
    if (c0 != 4 || c1 != 4 || q0.size() != 0 || q1.size() != 0) begin
      errors++; $display("FAIL rr_throughput: done0=%0d done1=%0d left=%0d/%0d, need 4 4 0 0",
                         c0, c1, q0.size(), q1.size());
    end
    req0_enable = 1'b0; req1_enable = 1'b0;
  endtask

  task automatic test_write();
    bit issued, seen;
    do_reset();
    lat = 2;
    issued = 0; seen = 0;
    req1_command = 1'b1; req1_addr = 32'h20; req1_wdata = 32'h12345678; req1_wstrb = 4'hF;
    req0_wdata = 32'h0; req0_wstrb = 4'h0; req0_command = 1'b0;
    for (int cyc = 0; cyc < 12 && !seen; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      req1_enable = issued ? 1'b0 : req1_ready;
      #1;
      if (!issued && mem_enable === 1'b1) begin
        issued = 1;
        checks++;
        if (cyc != 1 || mem_command !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'h12345678 || mem_wstrb !== 4'hF) begin
          errors++; $display("FAIL write_issue: cycle %0d cmd=%b addr=%h wdata=%h wstrb=%h, need cycle 1 1 20 12345678 f",
                             cyc, mem_command, mem_addr, mem_wdata, mem_wstrb);
        end
      end
      if (req0_valid === 1'b1) begin
        checks++; errors++; $display("FAIL write_wrong_port: req0_valid=1 need 0");
      end
      if (req1_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL write_done: req1_valid=0 within 12 cycles, need 1");
    end
    req1_enable = 1'b0;
  endtask

  task automatic test_stall();
    logic [31:0] e;
    do_reset();
    lat = 1;
    mem_ready = 1'b0;
    req0_command = 1'b0; req0_addr = 32'h344;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      req0_enable = req0_ready;
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || mem_enable !== 1'b0) begin
        errors++; $display("FAIL stall_hold[%0d]: r0=%b r1=%b en=%b, need 0 0 0", i, req0_ready, req1_ready, mem_enable);
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b1;
    #1;
    req0_enable = req0_ready;
    #1;
    checks++;
    if (mem_enable !== 1'b1 || req0_ready !== 1'b1 || mem_addr !== 32'h344) begin
      errors++; $display("FAIL stall_release: en=%b r0=%b addr=%h, need 1 1 344", mem_enable, req0_ready, mem_addr);
    end else q0.push_back(mem_fn(32'h344));
    @(posedge clk); #1;
    req0_enable = 1'b0;
    #1;
    checks++;
    e = (q0.size() != 0) ? q0.pop_front() : ~req_rdata;
    if (req0_valid !== 1'b1 || req_rdata !== e) begin
      errors++; $display("FAIL stall_response: v0=%b data=%h, need 1 %h", req0_valid, req_rdata, e);
    end
  endtask

  task automatic test_protocol_error();
    do_reset();
    mem_ready = 1'b1;
    inj_valid = 1'b1;
    #1;
    checks++;
    if (req0_valid !== 1'b0 || req1_valid !== 1'b0) begin
      errors++; $display("FAIL idle_valid_forward: v0=%b v1=%b, need 0 0", req0_valid, req1_valid);
    end
    @(posedge clk); #1;
    inj_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      #1;
      checks++;
      if (protocol_error !== 1'b1) begin
        errors++; $display("FAIL perr_sticky[%0d]: got %b need 1", i, protocol_error);
      end
    end
  endtask

  task automatic test_reset_busy();
    do_reset();
    checks++;
    if (protocol_error !== 1'b0) begin
      errors++; $display("FAIL perr_cleared: got %b need 0", protocol_error);
    end
    lat = 3;
    mem_ready = 1'b1;
    req0_command = 1'b0; req0_addr = 32'h88; req0_enable = 1'b1;
    #1;
    @(posedge clk); #1;
    req0_enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_valid !== 1'b1 || req0_valid !== 1'b0 || req1_valid !== 1'b0) begin
      errors++; $display("FAIL reset_wins: mem_valid=%b v0=%b v1=%b, need 1 0 0", mem_valid, req0_valid, req1_valid);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || protocol_error !== 1'b0 || owner !== 1'b0) begin
      errors++; $display("FAIL reset_in_busy: busy=%b perr=%b owner=%b, need 0 0 0", busy, protocol_error, owner);
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0;
    req0_enable = 1'b0; req0_command = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wstrb = '0;
    req1_enable = 1'b0; req1_command = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wstrb = '0;
    test_reset();
    test_read();
    test_back_to_back();
    test_write();
    test_stall();
    test_protocol_error();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within 100000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the core's single memory port between two requesters: port 0 (the CPU controller, for instruction fetch and load/store) and port 1 (DMA or debug loader). Each side uses the same ready/enable/valid handshake the controller already drives, so the controller connects unchanged. At most one transaction is outstanding. Round-robin offer rotation keeps either port from being starved.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- reqN_ready  out  1  (N = 0, 1) arbiter offers the memory port to requester N this cycle
- reqN_enable  in  1  requester issues a command; only legal while reqN_ready = 1
- reqN_command  in  1  0 = read, 1 = write
- reqN_addr  in  ADDR_WIDTH  byte address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_wstrb  in  DATA_WIDTH/8  byte write strobes
- reqN_valid  out  1  response for requester N (read data valid, or write done)
- req_rdata  out  DATA_WIDTH  read data, broadcast to both requesters; qualify with reqN_valid
- mem_ready  in  1  memory can accept a command
- mem_enable  out  1  command issued to memory
- mem_command, mem_addr, mem_wdata, mem_wstrb  out  command fields muxed from the selected requester
- mem_valid  in  1  memory completes the transaction
- mem_rdata  in  DATA_WIDTH  read data
- owner  out  1  requester that owns the in-flight transaction (debug)
- busy  out  1  a transaction is in flight
- protocol_error  out  1  sticky; set when mem_valid = 1 while idle

## Operation
- State: IDLE or BUSY. Registers: `offer` (1 bit, whose turn), `owner` (1 bit), `protocol_error`.
- In IDLE:
  - reqN_ready = mem_ready && offer == N. Only one port is ever offered.
  - mem_enable = req[offer]_enable && req[offer]_ready.
  - Memory command fields are muxed from req[offer].
- On an IDLE cycle with mem_enable = 1:
  - Next state is BUSY; owner ← offer; offer ← ~offer.
  - The other port gets first offer once the transaction completes.
- On an IDLE cycle with mem_ready = 1 and no enable:
  - offer ← ~offer.
  - An idle requester therefore never blocks the other for more than one cycle.
- On an IDLE cycle with mem_ready = 0: offer holds.
- In BUSY:
  - Both reqN_ready = 0 and mem_enable = 0.
  - Command fields are muxed from req[owner]. The requester must hold its fields stable until its valid, as the controller already does.
  - reqN_valid = mem_valid && owner == N. req_rdata = mem_rdata.
  - On mem_valid the state returns to IDLE; offer is unchanged (already rotated at issue).
- mem_valid in IDLE is not forwarded to either requester, and sets protocol_error.
- Reset values: state IDLE, offer 0, owner 0, protocol_error 0.
  - All outputs are 0 from the first cycle after reset, except mem_ready-dependent req0_ready.
  - Data and address outputs read req0 fields after reset.
- Reset mid-transaction abandons the transaction. A late mem_valid then sets protocol_error; memory must be reset alongside.

## Timing
- reqN_ready depends only on registers and mem_ready, never on reqN_enable. This avoids a combinational loop with the controller, whose enable depends on ready.
- mem_enable, mem fields, reqN_valid and req_rdata are combinational, with zero added latency on issue and response.
- Issue at cycle T with response at T+k gives busy over T+1..T+k. The next issue is possible at T+k+1 at the earliest.
- Back-to-back contention: port 0 issues at T; port 1 is offered first at T+k+1.
- Worst-case wait to be offered: 1 idle cycle plus one full transaction of the other port.
- Simultaneous mem_valid and reset: reset wins; no valid is forwarded.

## Test plan
- Reset, mem_ready = 1, no requests -> offer alternates 0,1,0,1 each cycle; req0_ready/req1_ready toggle one-hot; busy = 0.
- Port 0 read of 0x100 at cycle T, memory returns 0xDEADBEEF at T+3 -> mem_addr = 0x100 and owner = 0 over T..T+3; req0_valid = 1 only at T+3 with req_rdata = 0xDEADBEEF; req1_valid stays 0.
- Both ports request continuously with 2-cycle memory latency -> issues alternate 0,1,0,1; no port issues twice in a row; each port completes one transaction per 6 cycles.
- Port 1 write of 0x12345678 to 0x20 with wstrb 0xF while port 0 is idle -> mem_command = 1 and mem_wdata and mem_wstrb match on the issue cycle; req1_valid on completion.
- mem_ready = 0 for 5 cycles with port 0 offered -> offer holds at 0, no mem_enable; port 0 issues on the first cycle mem_ready rises.
- mem_valid pulsed while IDLE -> no reqN_valid; protocol_error = 1 and stays set until reset. Reset asserted during BUSY -> state IDLE and busy = 0 the following cycle.
